// File: rtl/spi_angle_rx.sv
// spi_angle_rx: SPI mode-0 slave that receives a 16-bit {angle_x, angle_y}
// word for the servo PWM stage, range-checks both bytes and echoes the last
// accepted word on miso during the next transfer.
//
// Optional feature macro: ANGLE_CLAMP_EN
//   defined   - an out-of-range angle byte is clamped to MAX_ANGLE and the
//               frame is accepted; length errors are still rejected.
//   undefined - any byte above MAX_ANGLE rejects the whole frame.
//
// Ports:
//   CLK        system clock
//   rst_n      asynchronous active-low reset
//   sck        SPI clock from host (asynchronous)
//   mosi       SPI data in (asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   miso       SPI data out, 0 when deselected
//   data_out   last accepted frame, [15:8]=angle_x, [7:0]=angle_y
//   rx_valid   one-cycle strobe, data_out updated
//   frame_err  one-cycle strobe, frame rejected
//   err_count  saturating rejected-frame counter
module spi_angle_rx #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned MAX_ANGLE   = 180,
  parameter int unsigned RESET_ANGLE = 90,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic [15:0] data_out,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int unsigned W  = 16;
  localparam int unsigned B  = 8;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = SYNC_STAGES + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(31);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);
  localparam logic [B-1:0]  MAX_B     = B'(MAX_ANGLE);
  localparam logic [B-1:0]  RST_B     = B'(RESET_ANGLE);
  localparam logic [B-1:0]  ERR_MAX   = B'(255);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  // Synchroniser chains; the extra top bit of sck/cs is the edge-history flop.
  logic [PW-1:0]          sck_pipe;
  logic [PW-1:0]          cs_pipe;
  logic [PW-1:0]          fill;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   armed;

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s, start;

  state_t         state, state_nxt;
  logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [W-1:0]   rx_shift, rx_shift_nxt;
  logic [W-1:0]   tx_shift, tx_shift_nxt;
  logic [W-1:0]   data_out_nxt;
  logic           rx_valid_nxt, frame_err_nxt, miso_nxt;
  logic [B-1:0]   err_count_nxt;
  logic           cs_hold, cs_hold_nxt;
  logic           len_ok, x_ok, y_ok;

  // Input synchronisers. cs_n resets high; arming waits until the chain holds
  // real samples and shows cs_n high, so a select held low across reset exit
  // never starts a frame.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[PW-2:0], sck};
      cs_pipe   <= {cs_pipe[PW-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[PW-2:0], 1'b1};
      armed     <= armed | (fill[PW-1] & cs_pipe[PW-1]);
    end
  end

  assign sck_rise = sck_pipe[PW-2] & ~sck_pipe[PW-1];
  assign sck_fall = ~sck_pipe[PW-2] & sck_pipe[PW-1];
  assign cs_rise  = cs_pipe[PW-2] & ~cs_pipe[PW-1];
  assign cs_fall  = ~cs_pipe[PW-2] & cs_pipe[PW-1] & armed;
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  // A select arriving during CHECK is held one cycle and honoured in IDLE.
  assign start    = cs_fall | cs_hold;

  assign len_ok = (bit_cnt == FRAME_CNT);
  assign x_ok   = (rx_shift[15:8] <= MAX_B);
  assign y_ok   = (rx_shift[7:0] <= MAX_B);

  // State register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    bit_cnt_nxt   = bit_cnt;
    rx_shift_nxt  = rx_shift;
    tx_shift_nxt  = tx_shift;
    data_out_nxt  = data_out;
    err_count_nxt = err_count;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    miso_nxt      = 1'b0;
    cs_hold_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          bit_cnt_nxt  = '0;
          tx_shift_nxt = data_out;
        end
      end
      ACTIVE: begin
        miso_nxt = tx_shift[W-1];
        if (sck_rise) begin
          rx_shift_nxt = {rx_shift[W-2:0], mosi_s};
          if (bit_cnt != CNT_MAX) bit_cnt_nxt = bit_cnt + CW'(1);
        end
        if (sck_fall) tx_shift_nxt = {tx_shift[W-2:0], 1'b0};
      end
      CHECK: begin
        cs_hold_nxt = cs_fall;
`ifdef ANGLE_CLAMP_EN
        if (len_ok) begin
          data_out_nxt = {(x_ok ? rx_shift[15:8] : MAX_B),
                          (y_ok ? rx_shift[7:0]  : MAX_B)};
          rx_valid_nxt = 1'b1;
        end else begin
`else
        if (len_ok && x_ok && y_ok) begin
          data_out_nxt = rx_shift;
          rx_valid_nxt = 1'b1;
        end else begin
`endif
          frame_err_nxt = 1'b1;
          if (err_count != ERR_MAX) err_count_nxt = err_count + B'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      data_out  <= {RST_B, RST_B};
      err_count <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      cs_hold   <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      rx_shift  <= rx_shift_nxt;
      tx_shift  <= tx_shift_nxt;
      data_out  <= data_out_nxt;
      err_count <= err_count_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      miso      <= miso_nxt;
      cs_hold   <= cs_hold_nxt;
    end
  end

endmodule

// File: tb/tb_spi_angle_rx.sv
// Bench for spi_angle_rx: directed SPI frames at CLK/8; expected strobes are
// queued by the driver and checked by an independent monitor.
module tb_spi_angle_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, mosi, cs_n;
  logic        miso;
  logic [15:0] data_out;
  logic        rx_valid, frame_err;
  logic [7:0]  err_count;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
    logic [7:0]  errc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic [7:0]  err_exp = 8'd0;
  logic [15:0] mw;

  spi_angle_rx dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #10 clk = ~clk;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rx_valid || frame_err) begin
      tests++;
      if (rx_valid && frame_err) begin
        fails++;
        $display("FAIL both_strobes rx_valid=%0b frame_err=%0b required not both", rx_valid, frame_err);
      end else if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe rx_valid=%0b frame_err=%0b data_out=%h", rx_valid, frame_err, data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (frame_err !== e.err || rx_valid !== !e.err || data_out !== e.data || err_count !== e.errc) begin
          fails++;
          $display("FAIL strobe got err=%0b data=%h errc=%0d required err=%0b data=%h errc=%0d",
                   frame_err, data_out, err_count, e.err, e.data, e.errc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic m);
    mosi = b;
    wait_neg(4);
    sck = 1'b1;
    wait_neg(4);
    m = miso;
    sck = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input logic exp_err,
                            input logic [15:0] exp_data, input logic chk_lat,
                            output logic [15:0] word);
    logic m;
    exp_t e;
    int   lat;
    @(negedge clk);
    cs_n = 1'b0;
    wait_neg(8);
    word = '0;
    for (int i = 0; i < n; i++) begin
      clock_bit(bits[n-1-i], m);
      word = {word[14:0], m};
    end
    wait_neg(4);
    if (exp_err && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    e.err = exp_err; e.data = exp_data; e.errc = err_exp;
    q.push_back(e);
    cs_n = 1'b1;
    mosi = 1'b0;
    if (chk_lat) begin
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        @(posedge clk);
        #1;
        if (rx_valid) lat = k;
      end
      check("rx_valid_latency", 32'(lat), 32'd4);
    end
    wait_neg(12);
  endtask

  initial begin
    logic m;
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    wait_neg(5);
    rst_n = 1'b1;
    wait_neg(10);
    check("reset_data_out", 32'(data_out), 32'h5A5A);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);

    send_frame(32'h2D87, 16, 1'b0, 16'h2D87, 1'b1, mw);
    send_frame(32'h0000, 16, 1'b0, 16'h0000, 1'b0, mw);
    check("miso_echo", 32'(mw), 32'h2D87);
    check("miso_deselected", 32'(miso), 32'd0);

    send_frame(32'h2D87, 15, 1'b1, 16'h0000, 1'b0, mw);
    send_frame(32'h12D87, 17, 1'b1, 16'h0000, 1'b0, mw);
    check("len_err_count", 32'(err_count), 32'd2);
    check("len_err_data_held", 32'(data_out), 32'h0000);

    send_frame(32'hB45A, 16, 1'b0, 16'hB45A, 1'b1, mw);
`ifdef ANGLE_CLAMP_EN
    send_frame(32'hB55A, 16, 1'b0, 16'hB45A, 1'b0, mw);
    send_frame(32'h5AB5, 16, 1'b0, 16'h5AB4, 1'b0, mw);
    check("clamp_err_count", 32'(err_count), 32'd2);
`else
    send_frame(32'hB55A, 16, 1'b1, 16'hB45A, 1'b0, mw);
    send_frame(32'h5AB5, 16, 1'b1, 16'hB45A, 1'b0, mw);
    check("range_err_count", 32'(err_count), 32'd4);
    check("range_data_held", 32'(data_out), 32'hB45A);
`endif

    // Reset in the middle of a frame, then let the host finish clocking.
    @(negedge clk);
    cs_n = 1'b0;
    wait_neg(8);
    for (int i = 0; i < 8; i++) clock_bit(1'b1, m);
    rst_n = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    err_exp = 8'd0;
    for (int i = 0; i < 8; i++) clock_bit(1'b0, m);
    wait_neg(4);
    cs_n = 1'b1;
    wait_neg(15);
    check("midreset_data_out", 32'(data_out), 32'h5A5A);
    check("midreset_err_count", 32'(err_count), 32'd0);

    send_frame(32'h1E3C, 16, 1'b0, 16'h1E3C, 1'b1, mw);
    check("fresh_data_out", 32'(data_out), 32'h1E3C);

    for (int k = 0; k < 300; k++) send_frame(32'h1, k % 3, 1'b1, 16'h1E3C, 1'b0, mw);
    check("err_saturated", 32'(err_count), 32'hFF);
    check("sat_data_held", 32'(data_out), 32'h1E3C);

    wait_neg(20);
    check("all_strobes_seen", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
